// File: rtl/pipe_pkg.sv
// Shared widths and the per-stage record for the pipe_stages slice.
package pipe_pkg;

    localparam int PC_W_DEF   = 12;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_MAX  = 8;

    // Contents of one pipeline stage at the default widths.
    typedef struct packed {
        logic                  valid;
        logic [PC_W_DEF-1:0]   pc;
        logic [DATA_W_DEF-1:0] data;
    } stage_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid bit, PC tag and payload.
// A flush clears valid and takes priority over any load.
// When the stage is disabled, every field holds its value.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              flush,
    input  logic              prev_valid,
    input  logic [PC_W-1:0]   prev_pc,
    input  logic [DATA_W-1:0] prev_data,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] data
);

    // Valid and PC are reset; flush kills the entry, enable advances it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (en) begin
            valid <= prev_valid;
            pc    <= prev_pc;
        end
    end

    // Payload is not reset; it only needs to be correct while valid is set.
    always_ff @(posedge clk) begin
        if (en) begin
            data <= prev_data;
        end
    end

endmodule

// File: rtl/pipe_stages.sv
// Elastic register pipeline of DEPTH stages. The ready chain is
// combinational, so bubbles collapse without a penalty.
// Optional feature: define PIPE_STAGES_PERF_EN to add the stall_cnt and
// bubble_cnt performance counters.
module pipe_stages
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int DEPTH  = 5            // legal range 1..DEPTH_MAX
) (
    input  logic                 CLK100MHZ,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [DATA_W-1:0]    out_data,
    input  logic                 flush,
    output logic [DEPTH-1:0]     stage_valid,
    output logic [DEPTH*PC_W-1:0] stage_pc
`ifdef PIPE_STAGES_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          bubble_cnt
`endif
);

    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] en;
    logic [PC_W-1:0]   pc_arr   [DEPTH];
    logic [DATA_W-1:0] data_arr [DEPTH];

    // Enable chain in closed form: a stage may load if downstream accepts
    // or any stage from here to the end is empty. This avoids a
    // bit-to-bit dependency inside the enable vector.
    always_comb begin
        logic acc;
        acc = out_ready;
        en  = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            acc = acc | ~valid_vec[DEPTH-1-k];
            en[DEPTH-1-k] = acc;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            if (g == 0) begin : g_first
                pipe_stage_reg #(
                    .PC_W   (PC_W),
                    .DATA_W (DATA_W)
                ) u_stage (
                    .clk        (CLK100MHZ),
                    .rst        (rst),
                    .en         (en[g]),
                    .flush      (flush),
                    .prev_valid (in_valid),
                    .prev_pc    (in_pc),
                    .prev_data  (in_data),
                    .valid      (valid_vec[g]),
                    .pc         (pc_arr[g]),
                    .data       (data_arr[g])
                );
            end else begin : g_next
                pipe_stage_reg #(
                    .PC_W   (PC_W),
                    .DATA_W (DATA_W)
                ) u_stage (
                    .clk        (CLK100MHZ),
                    .rst        (rst),
                    .en         (en[g]),
                    .flush      (flush),
                    .prev_valid (valid_vec[g-1]),
                    .prev_pc    (pc_arr[g-1]),
                    .prev_data  (data_arr[g-1]),
                    .valid      (valid_vec[g]),
                    .pc         (pc_arr[g]),
                    .data       (data_arr[g])
                );
            end

            // Debug view: an empty stage shows a zero tag.
            assign stage_pc[g*PC_W +: PC_W] = valid_vec[g] ? pc_arr[g] : '0;
        end
    endgenerate

    assign stage_valid = valid_vec;
    assign in_ready    = en[0] & ~flush & ~rst;
    assign out_valid   = valid_vec[DEPTH-1] & ~flush;
    assign out_pc      = pc_arr[DEPTH-1];
    assign out_data    = data_arr[DEPTH-1];

`ifdef PIPE_STAGES_PERF_EN
    // Saturating stall/bubble counters, cleared by reset or flush.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (!out_valid && out_ready && !(&bubble_cnt)) begin
                bubble_cnt <= bubble_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stages.sv
// Directed testbench for pipe_stages (DEPTH=5, PC_W=12, DATA_W=32).
module tb_pipe_stages;

    localparam int DEPTH  = 5;
    localparam int PC_W   = 12;
    localparam int DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [PC_W-1:0]         in_pc;
    logic [DATA_W-1:0]       in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [PC_W-1:0]         out_pc;
    logic [DATA_W-1:0]       out_data;
    logic                    flush;
    logic [DEPTH-1:0]        stage_valid;
    logic [DEPTH*PC_W-1:0]   stage_pc;
`ifdef PIPE_STAGES_PERF_EN
    logic [31:0]             stall_cnt;
    logic [31:0]             bubble_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stages #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK100MHZ   (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_data    (out_data),
        .flush       (flush),
        .stage_valid (stage_valid),
        .stage_pc    (stage_pc)
`ifdef PIPE_STAGES_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
`endif
    );

    function automatic logic [DATA_W-1:0] dat(input logic [PC_W-1:0] pc);
        return 32'hD00D_0000 | {20'h0, pc};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; in_pc = 12'h7FF; in_data = '1;
        out_ready = 1'b1; flush = 1'b0;
        step;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (stage_valid !== '0) begin bad++; $display("FAIL rst_stage_valid got=%b exp=0", stage_valid); end
        total++; if (stage_pc !== '0) begin bad++; $display("FAIL rst_stage_pc got=%h exp=0", stage_pc); end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        step;
    endtask

    task automatic test_latency;
        logic exp_v;
        logic [PC_W-1:0] exp_pc;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c < 3); in_pc = 12'(4 * c); in_data = dat(in_pc); out_ready = 1'b1;
            #1;
            if (c < 3) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready c=%0d got=%b exp=1", c, in_ready); end
            end
            exp_v = (c >= 5 && c <= 7);
            total++; if (out_valid !== exp_v) begin bad++; $display("FAIL lat_out_valid c=%0d got=%b exp=%b", c, out_valid, exp_v); end
            if (exp_v) begin
                exp_pc = 12'(4 * (c - 5));
                total++; if (out_pc !== exp_pc || out_data !== dat(exp_pc)) begin
                    bad++; $display("FAIL lat_out c=%0d got=%h/%h exp=%h/%h", c, out_pc, out_data, exp_pc, dat(exp_pc));
                end
            end
            step;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_fill;
        logic [PC_W-1:0] exp_pc;
        int idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = 1'b1; in_pc = 12'h010 + 12'(4 * idx); in_data = dat(in_pc);
            #1;
            total++; if (in_ready !== (c < 5)) begin bad++; $display("FAIL fill_in_ready c=%0d got=%b exp=%b", c, in_ready, (c < 5)); end
            if (c < 5) idx++;
            step;
        end
        in_valid = 1'b0;
        #1;
        total++; if (stage_valid !== 5'b11111) begin bad++; $display("FAIL fill_stage_valid got=%b exp=11111", stage_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
        for (int s = 0; s < 2; s++) begin
            total++; if (out_valid !== 1'b1 || out_pc !== 12'h010 || out_data !== dat(12'h010)) begin
                bad++; $display("FAIL fill_stall s=%0d got=%b/%h/%h exp=1/010/%h", s, out_valid, out_pc, out_data, dat(12'h010));
            end
            step;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_pc = 12'h010 + 12'(4 * k);
            total++; if (out_valid !== 1'b1 || out_pc !== exp_pc || out_data !== dat(exp_pc)) begin
                bad++; $display("FAIL fill_drain k=%0d got=%b/%h/%h exp=1/%h/%h", k, out_valid, out_pc, out_data, exp_pc, dat(exp_pc));
            end
            step;
        end
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", out_valid); end
        step;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_pc = 12'h200 + 12'(4 * c); in_data = dat(in_pc);
            step;
        end
        in_valid = 1'b1; in_pc = 12'h2F0; in_data = dat(in_pc); flush = 1'b1;
        #1;
        total++; if (stage_valid !== 5'b11111) begin bad++; $display("FAIL flush_pre_full got=%b exp=11111", stage_valid); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        step;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (stage_valid !== '0) begin bad++; $display("FAIL flush_stage_valid got=%b exp=0", stage_valid); end
        total++; if (stage_pc !== '0) begin bad++; $display("FAIL flush_stage_pc got=%h exp=0", stage_pc); end
        out_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_no_accept c=%0d got=%b exp=0", c, out_valid); end
            step;
        end
    endtask

    task automatic test_toggle;
        localparam int N = 6;
        int sent = 0;
        int rcvd = 0;
        logic [PC_W-1:0] exp_pc;
        for (int c = 0; c < 60 && rcvd < N; c++) begin
            out_ready = (c % 2 == 0);
            in_valid  = (sent < N);
            in_pc     = 12'h300 + 12'(4 * sent);
            in_data   = dat(in_pc);
            #1;
            if (out_valid) begin
                exp_pc = 12'h300 + 12'(4 * rcvd);
                total++; if (out_pc !== exp_pc || out_data !== dat(exp_pc)) begin
                    bad++; $display("FAIL toggle_out c=%0d rdy=%b got=%h/%h exp=%h/%h", c, out_ready, out_pc, out_data, exp_pc, dat(exp_pc));
                end
                if (out_ready) rcvd++;
            end
            if (in_valid && in_ready) sent++;
            step;
        end
        in_valid = 1'b0;
        total++; if (rcvd !== N) begin bad++; $display("FAIL toggle_count got=%0d exp=%0d", rcvd, N); end
        out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || stage_valid !== '0) begin
            bad++; $display("FAIL toggle_extra got=%b/%b exp=0/00000", out_valid, stage_valid);
        end
        step;
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; in_pc = 12'h400 + 12'(4 * c); in_data = dat(in_pc);
            step;
        end
        in_valid = 1'b0;
        #1;
        total++; if (stage_valid !== 5'b00111) begin bad++; $display("FAIL arst_pre got=%b exp=00111", stage_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (stage_valid !== '0) begin bad++; $display("FAIL arst_stage_valid got=%b exp=0", stage_valid); end
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL arst_handshake got=%b/%b exp=0/0", out_valid, in_ready);
        end
        total++; if (stage_pc !== '0) begin bad++; $display("FAIL arst_stage_pc got=%h exp=0", stage_pc); end
        #3 rst = 1'b0;
        step;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c == 0); in_pc = 12'h100; in_data = dat(12'h100); out_ready = 1'b1;
            #1;
            if (c == 0) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
            end
            total++; if (out_valid !== (c == 5)) begin bad++; $display("FAIL arst_lat c=%0d got=%b exp=%b", c, out_valid, (c == 5)); end
            if (c == 5) begin
                total++; if (out_pc !== 12'h100 || out_data !== dat(12'h100)) begin
                    bad++; $display("FAIL arst_out got=%h/%h exp=100/%h", out_pc, out_data, dat(12'h100));
                end
            end
            step;
        end
        in_valid = 1'b0;
    endtask

`ifdef PIPE_STAGES_PERF_EN
    task automatic test_perf;
        flush = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step;
        flush = 1'b0;
        in_valid = 1'b1; in_pc = 12'h500; in_data = dat(12'h500);
        step;
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) step;
        out_ready = 1'b1;
        step;
        step;
        step;
        out_ready = 1'b0;
        #1;
        total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL perf_stall got=%0d exp=4", stall_cnt); end
        total++; if (bubble_cnt !== 32'd2) begin bad++; $display("FAIL perf_bubble got=%0d exp=2", bubble_cnt); end
        flush = 1'b1;
        step;
        flush = 1'b0;
        #1;
        total++; if (stall_cnt !== '0 || bubble_cnt !== '0) begin
            bad++; $display("FAIL perf_flush got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt);
        end
        step;
    endtask
`endif

    initial begin
        test_reset;
        test_latency;
        test_fill;
        test_flush;
        test_toggle;
        test_async_reset;
`ifdef PIPE_STAGES_PERF_EN
        test_perf;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stages.md
PIPE_STAGES -- requirements
Module: pipe_stages

Interface
REQ-001 Parameter DATA_W, default 32: payload width carried per stage.
REQ-002 Parameter PC_W, default 12: PC tag width carried per stage.
REQ-003 Parameter DEPTH, default 5: number of register stages; legal range 1..8.
REQ-004 CLK100MHZ  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers an entry.
REQ-007 in_ready  output  1  stage 0 accepts an entry this cycle.
REQ-008 in_pc  input  PC_W  PC tag of the offered entry.
REQ-009 in_data  input  DATA_W  payload of the offered entry.
REQ-010 out_valid  output  1  last stage holds a valid entry.
REQ-011 out_ready  input  1  downstream accepts the last-stage entry.
REQ-012 out_pc, out_data  output  PC_W, DATA_W  last-stage tag and payload.
REQ-013 flush  input  1  kill every in-flight entry.
REQ-014 stage_valid  output  DEPTH  per-stage valid bits; bit 0 = first stage.
REQ-015 stage_pc  output  DEPTH*PC_W  per-stage PC tags for debug; slice i = stage i.

Function
REQ-016 Each stage SHALL hold a valid bit, PC tag and payload register.
REQ-017 Stage i SHALL load from stage i-1 (stage 0 from the input) when its enable is high: enable_i = !valid_i OR enable_(i+1); the last stage uses enable = !out_valid OR out_ready.
REQ-018 in_ready SHALL equal enable_0 AND !flush; the ready chain is combinational, with no bubble penalty.
REQ-019 An advancing stage SHALL take valid from its predecessor; an empty predecessor inserts a bubble.
REQ-020 A stage whose enable is low SHALL hold all of its fields.
REQ-021 Latency: with out_ready held high, an entry accepted in cycle N SHALL appear at the output in cycle N+DEPTH.
REQ-022 Throughput SHALL be one entry per cycle when out_ready is continuously high.
REQ-023 With out_ready low the pipe SHALL fill completely, holding DEPTH entries; in_ready SHALL drop only when all stages are valid.
REQ-024 flush SHALL clear every valid bit at the next edge, with priority over all loads.
REQ-025 In a flush cycle, out_valid SHALL be forced low and no input SHALL be accepted.
REQ-026 The stage_pc slice of an invalid stage SHALL read 0; payload registers are not cleared.
REQ-027 The output handshake completes when out_valid AND out_ready are both high; out_pc and out_data SHALL stay stable while out_valid=1 and out_ready=0.

Reset
REQ-028 rst SHALL asynchronously clear all valid bits and all PC registers; payload registers are don't-care.
REQ-029 During reset, in_ready and out_valid SHALL be 0 and stage_pc SHALL be all zero.
REQ-030 rst asserted mid-stream SHALL discard all entries; the first cycle after release behaves as an empty pipe.

Configuration
REQ-031 Macro PIPE_STAGES_PERF_EN, when defined, SHALL add two 32-bit outputs:
- stall_cnt: cycles where out_valid=1 and out_ready=0.
- bubble_cnt: cycles where out_valid=0 and out_ready=1.
REQ-032 Both counters SHALL reset to 0, saturate at 0xFFFFFFFF, and clear on flush.
REQ-033 Without PIPE_STAGES_PERF_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-034 A shared package pipe_pkg SHALL hold the default widths (PC_W_DEF=12, DATA_W_DEF=32, DEPTH_MAX=8) and a stage record typedef {valid, pc, data}.
REQ-035 One sub-module, pipe_stage_reg (a single stage with enable and flush), SHALL be instantiated DEPTH times via generate.

Verification
REQ-036 DEPTH=5, out_ready=1; send PC 0x000, 0x004, 0x008 in consecutive cycles -> outputs appear in cycles 5, 6, 7, in order, with no gaps.
REQ-037 out_ready=0; offer 7 entries -> 5 accepted, in_ready=0 afterwards, stage_valid=5'b11111; raising out_ready drains all 5 in order.
REQ-038 Full pipe, flush pulsed 1 cycle together with in_valid=1 -> out_valid=0 in that cycle, stage_valid=0 and stage_pc=0 the next cycle, offered entry not accepted.
REQ-039 Stream with out_ready toggling 1,0,1,0 -> no entry lost or duplicated; out_data stable across every stalled cycle.
REQ-040 rst asserted asynchronously between edges with 3 valid entries -> stage_valid=0 immediately; after release, a new PC 0x100 exits at latency 5.
REQ-041 With PIPE_STAGES_PERF_EN: 4 stalled cycles then 2 idle cycles -> stall_cnt=4, bubble_cnt=2; flush -> both 0.
